// File: rtl/memtest_sweep_log.sv
// Per-slot pass/fail/timeout verdict recorder for the SDRAM tester sweep; done one cycle after the RUN hit, map one later.
// Optional MEMTEST_LOG_STICKY_FAIL_EN: a recorded fail/timeout is never replaced by a later pass.
module memtest_sweep_log #(
   parameter int SLOTS       = 11,
   parameter int PASS_TARGET = 4,
   parameter int TIMEOUT_CYC = 100000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           slot_i,
   input  logic                 clear,
   input  logic                 tester_rst,
   input  logic [31:0]          passcount,
   input  logic [31:0]          failcount,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           verdict,
   output logic [2*SLOTS-1:0]   status_map,
   output logic [3:0]           best_slot,
   output logic [3:0]           pass_slots
);

   localparam logic [31:0] SLOTS_W   = SLOTS;
   localparam logic [31:0] PASS_TGT  = PASS_TARGET;
   localparam logic [31:0] WDOG_LAST = TIMEOUT_CYC - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_SNAP,
      S_RUN,
      S_RECORD
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           slot_q, slot_d;
   logic [31:0]          pass_base_q, pass_base_d;
   logic [31:0]          fail_base_q, fail_base_d;
   logic [31:0]          wdog_q, wdog_d;
   logic [1:0]           verdict_q, verdict_d;
   logic [2*SLOTS-1:0]   map_q, map_d;
   logic [3:0]           best_q, best_d;
   logic [3:0]           npass_q, npass_d;
   logic [31:0]          pass_delta;

   // Modular difference keeps a passcount wrap between snapshot and check harmless.
   assign pass_delta = passcount - pass_base_q;

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      pass_base_d = pass_base_q;
      fail_base_d = fail_base_q;
      wdog_d      = wdog_q;
      verdict_d   = verdict_q;
      map_d       = map_q;

      case (state_q)
         S_IDLE: begin
            if (start && ({28'd0, slot_i} < SLOTS_W)) begin
               slot_d  = slot_i;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (!tester_rst) state_d = S_SNAP;
         end
         S_SNAP: begin
            if (tester_rst) begin
               state_d = S_ARM;
            end else begin
               pass_base_d = passcount;
               fail_base_d = failcount;
               wdog_d      = '0;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            if (tester_rst) begin
               state_d = S_ARM;
            end else if (failcount != fail_base_q) begin
               verdict_d = 2'b10;
               state_d   = S_RECORD;
            end else if (pass_delta >= PASS_TGT) begin
               verdict_d = 2'b01;
               state_d   = S_RECORD;
            end else if (wdog_q == WDOG_LAST) begin
               verdict_d = 2'b11;
               state_d   = S_RECORD;
            end else begin
               wdog_d = wdog_q + 32'd1;
            end
         end
         S_RECORD: begin
            state_d = S_IDLE;
            for (int i = 0; i < SLOTS; i++) begin
               if (slot_q == i[3:0]) begin
`ifdef MEMTEST_LOG_STICKY_FAIL_EN
                  if (!(verdict_q == 2'b01 && map_q[2*i+1]))
                     map_d[2*i +: 2] = verdict_q;
`else
                  map_d[2*i +: 2] = verdict_q;
`endif
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (clear) begin
         state_d = S_IDLE;
         map_d   = '0;
      end
   end

   // Summary is derived from the registered map, so it trails the map by one cycle.
   always_comb begin
      best_d  = 4'hF;
      npass_d = 4'd0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (map_q[2*i +: 2] == 2'b01) begin
            best_d  = i[3:0];
            npass_d = npass_d + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         slot_q      <= '0;
         pass_base_q <= '0;
         fail_base_q <= '0;
         wdog_q      <= '0;
         verdict_q   <= '0;
         map_q       <= '0;
         best_q      <= 4'hF;
         npass_q     <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         pass_base_q <= pass_base_d;
         fail_base_q <= fail_base_d;
         wdog_q      <= wdog_d;
         verdict_q   <= verdict_d;
         map_q       <= map_d;
         best_q      <= best_d;
         npass_q     <= npass_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_RECORD) && !clear;
   assign verdict    = done ? verdict_q : 2'b00;
   assign status_map = map_q;
   assign best_slot  = best_q;
   assign pass_slots = npass_q;

endmodule

// File: tb/tb_memtest_sweep_log.sv
// Bench for memtest_sweep_log: planned count/reset trajectories judged by a cycle-indexed reference model.
module tb_memtest_sweep_log;
   localparam int SLOTS = 11;
   localparam int PT    = 4;
   localparam int TO    = 50;

   logic clk = 1'b0;
   logic reset, start, clear, tester_rst;
   logic [3:0] slot_i;
   logic [31:0] passcount, failcount;
   logic busy, done;
   logic [1:0] verdict;
   logic [2*SLOTS-1:0] status_map;
   logic [3:0] best_slot, pass_slots;

   memtest_sweep_log #(.SLOTS(SLOTS), .PASS_TARGET(PT), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .slot_i(slot_i), .clear(clear),
      .tester_rst(tester_rst), .passcount(passcount), .failcount(failcount),
      .busy(busy), .done(done), .verdict(verdict), .status_map(status_map),
      .best_slot(best_slot), .pass_slots(pass_slots));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [1:0] mdl_map [SLOTS];

   // Trajectory plan, indexed by cycle offset from the start pulse.
   logic [31:0] p_base, f_base;
   int p_per, f_at, r_at, r_len;
   int obs_dc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pc(input int j);
      return (p_per == 0) ? p_base : p_base + 32'(j / p_per);
   endfunction

   function automatic logic [31:0] fc(input int j);
      return (f_at >= 0 && j >= f_at) ? f_base + 32'd1 : f_base;
   endfunction

   function automatic logic rst(input int j);
      return (r_len > 0 && j >= r_at && j < r_at + r_len);
   endfunction

   function automatic logic [2*SLOTS-1:0] exp_map();
      logic [2*SLOTS-1:0] m;
      for (int i = 0; i < SLOTS; i++) m[2*i +: 2] = mdl_map[i];
      return m;
   endfunction

   function automatic logic [3:0] exp_best();
      logic [3:0] b = 4'hF;
      for (int i = SLOTS - 1; i >= 0; i--) if (mdl_map[i] == 2'b01) b = 4'(i);
      return b;
   endfunction

   function automatic logic [3:0] exp_npass();
      logic [3:0] n = 0;
      for (int i = 0; i < SLOTS; i++) if (mdl_map[i] == 2'b01) n++;
      return n;
   endfunction

   task automatic mdl_record(input int s, input logic [1:0] v);
`ifdef MEMTEST_LOG_STICKY_FAIL_EN
      if (!(v == 2'b01 && mdl_map[s][1])) mdl_map[s] = v;
`else
      mdl_map[s] = v;
`endif
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < SLOTS; i++) mdl_map[i] = 2'b00;
   endtask

   // A test window opens with a snapshot the cycle after the tester leaves reset;
   // any tester reset inside the window abandons it and waits for the next release.
   task automatic predict(output int dcyc, output logic [1:0] v);
      int j, snap;
      logic [31:0] pb, fb;
      dcyc = -1;
      v    = 2'b00;
      j    = 1;
      while (dcyc < 0 && j < 5000) begin
         while (rst(j)) j++;
         snap = j + 1;
         if (rst(snap)) begin
            j = snap + 1;
            continue;
         end
         pb = pc(snap);
         fb = fc(snap);
         for (int e = snap + 1; e <= snap + TO; e++) begin
            if (rst(e)) begin
               j = e + 1;
               break;
            end
            if (fc(e) != fb) begin
               v = 2'b10; dcyc = e + 1; break;
            end
            if (pc(e) - pb >= 32'(PT)) begin
               v = 2'b01; dcyc = e + 1; break;
            end
            if (e - (snap + 1) == TO - 1) begin
               v = 2'b11; dcyc = e + 1; break;
            end
         end
      end
   endtask

   task automatic drive(input int j);
      passcount  = pc(j);
      failcount  = fc(j);
      tester_rst = rst(j);
   endtask

   task automatic run(input int slot, input string tag);
      int dc;
      logic [1:0] v;
      predict(dc, v);
      obs_dc = -1;
      start  = 1'b1;
      slot_i = 4'(slot);
      drive(0);
      for (int j = 1; j <= dc + 2; j++) begin
         step();
         start = 1'b0;
         drive(j);
         if (done === 1'b1 && obs_dc < 0) obs_dc = j;
         chk({tag, ".done"}, 32'(done), 32'(j == dc));
         chk({tag, ".busy"}, 32'(busy), 32'(j <= dc));
         if (j == dc) begin
            chk({tag, ".verdict"}, 32'(verdict), 32'(v));
            mdl_record(slot, v);
         end
         if (j == dc + 1) chk({tag, ".map"}, 32'(status_map), 32'(exp_map()));
         if (j == dc + 2) begin
            chk({tag, ".best"}, 32'(best_slot), 32'(exp_best()));
            chk({tag, ".npass"}, 32'(pass_slots), 32'(exp_npass()));
         end
      end
   endtask

   task automatic plan(input logic [31:0] pb, input int per, input int fat, input int rat, input int rlen);
      p_base = pb;
      f_base = $urandom;
      p_per  = per;
      f_at   = fat;
      r_at   = rat;
      r_len  = rlen;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; clear = 1'b0; tester_rst = 1'b0;
      slot_i = '0; passcount = '0; failcount = '0;
      mdl_clear();
      plan(32'd0, 0, -1, 0, 0);
      repeat (3) step();
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk("rst.verdict", 32'(verdict), 0);
      chk("rst.map", 32'(status_map), 0);
      chk("rst.best", 32'(best_slot), 32'hF);
      chk("rst.npass", 32'(pass_slots), 0);
      reset = 1'b0;
      step();

      plan($urandom, 10, -1, 0, 0);
      run(3, "pass");
      chk("pass.slot3", 32'(status_map[7:6]), 32'b01);
      chk("pass.best3", 32'(best_slot), 32'd3);
      chk("pass.cnt1", 32'(pass_slots), 32'd1);

      plan($urandom, 2, 10, 0, 0);
      run(5, "failpri");
      chk("failpri.slot5", 32'(status_map[11:10]), 32'b10);

      plan($urandom, 0, -1, 0, 0);
      run(7, "timeout");
      chk("timeout.latency", 32'(obs_dc), 32'd53);

      plan(32'hFFFFFFFC, 1, -1, 0, 0);
      run(1, "wrap");
      chk("wrap.slot1", 32'(status_map[3:2]), 32'b01);

      plan($urandom, 4, -1, 8, 20);
      run(2, "reconf");
      chk("reconf.latency", 32'(obs_dc), 32'd45);

      clear = 1'b1;
      step();
      clear = 1'b0;
      mdl_clear();
      chk("clr.map", 32'(status_map), 0);
      plan($urandom, 0, 5, 0, 0);
      run(0, "sticky.fail");
      plan($urandom, 1, -1, 0, 0);
      run(0, "sticky.pass");
`ifdef MEMTEST_LOG_STICKY_FAIL_EN
      chk("sticky.slot0", 32'(status_map[1:0]), 32'b10);
      chk("sticky.best", 32'(best_slot), 32'hF);
`else
      chk("sticky.slot0", 32'(status_map[1:0]), 32'b01);
      chk("sticky.best", 32'(best_slot), 32'd0);
`endif

      start = 1'b1; clear = 1'b1; slot_i = 4'd4;
      step();
      start = 1'b0; clear = 1'b0;
      mdl_clear();
      chk("clrstart.busy", 32'(busy), 0);
      chk("clrstart.map", 32'(status_map), 0);
      step();
      chk("clrstart.best", 32'(best_slot), 32'hF);
      chk("clrstart.npass", 32'(pass_slots), 0);

      plan($urandom, 0, -1, 0, 0);
      start = 1'b1; slot_i = 4'd6; drive(0);
      step();
      start = 1'b0;
      repeat (5) step();
      chk("clrrun.busy_before", 32'(busy), 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int k = 0; k < 60; k++) begin
         chk("clrrun.done", 32'(done), 0);
         chk("clrrun.busy", 32'(busy), 0);
         step();
      end
      chk("clrrun.map", 32'(status_map), 0);

      for (int s = 11; s <= 15; s += 4) begin
         start = 1'b1; slot_i = 4'(s);
         step();
         start = 1'b0;
         chk("badslot.busy", 32'(busy), 0);
         step();
         chk("badslot.busy2", 32'(busy), 0);
      end

      for (int r = 0; r < 12; r++) begin
         int fat, rlen;
         fat  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 60)) : -1;
         rlen = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 25)) : 0;
         plan($urandom, int'($urandom_range(0, 12)), fat, int'($urandom_range(2, 30)), rlen);
         run(int'($urandom_range(0, SLOTS - 1)), "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/memtest_sweep_log.md
# memtest_sweep_log

Per-frequency verdict recorder for the SDRAM memory tester. It sits directly downstream of the tester, in the tester's `clk_ram` domain, and consumes the free-running `passcount`/`failcount` after each PLL step. It decides pass, fail or timeout for the current frequency slot and keeps a per-slot status map. Its `done`/`verdict` pulse drives the auto-sweep advance, and its summary outputs feed the results display.

## Interface
Parameters:
- `SLOTS`, 11: number of frequency slots; slot 0 is the highest frequency.
- `PASS_TARGET`, 4: passcount increments with no failures needed to declare a pass.
- `TIMEOUT_CYC`, 100000000: cycles in RUN without a verdict before a timeout is declared.

Ports:
- `clk`  in  1  tester/SDRAM clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; begin judging slot `slot_i`.
- `slot_i`  in  4  slot index, sampled on `start`.
- `clear`  in  1  one-cycle pulse; wipe all records.
- `tester_rst`  in  1  high while the tester is held in reset.
- `passcount`  in  32  from tester.
- `failcount`  in  32  from tester.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle verdict pulse.
- `verdict`  out  2  01 pass, 10 fail, 11 timeout; valid while `done`=1.
- `status_map`  out  2*SLOTS  2 bits per slot, slot n at [2n+1:2n]; 00 untested, 01 pass, 10 fail, 11 timeout.
- `best_slot`  out  4  lowest index with status 01; 4'hF if there is none.
- `pass_slots`  out  4  number of slots with status 01.

## Operation
- FSM states: IDLE, ARM, SNAP, RUN, RECORD.
- IDLE:
  - `start` with `slot_i` < SLOTS latches the slot and goes to ARM.
  - `start` with `slot_i` >= SLOTS is ignored.
  - `start` in any other state is ignored.
- ARM: wait for `tester_rst`=0, then go to SNAP.
- SNAP: capture `pass_base`=`passcount` and `fail_base`=`failcount`, clear the watchdog, go to RUN.
- RUN: evaluate every cycle, priority fail > pass > timeout:
  - fail: `failcount` != `fail_base`.
  - pass: (`passcount` - `pass_base`) mod 2^32 >= PASS_TARGET.
  - timeout: watchdog == TIMEOUT_CYC-1.
  - Any hit latches the verdict and goes to RECORD.
- Modular subtraction makes counter wrap-around transparent.
- `tester_rst` rising in RUN or SNAP returns the FSM to ARM. This covers a PLL reconfig mid-test. Baselines and watchdog are re-captured later.
- RECORD:
  - `done`=1 and `verdict` driven.
  - `status_map[slot]` written at the clock edge that leaves RECORD.
  - Next state IDLE.
- `clear` in any state: the FSM goes to IDLE and `status_map` is zeroed. Any pending verdict is discarded with no `done`. `clear` wins over a simultaneous `start`.
- `best_slot` and `pass_slots` are registered and recomputed from `status_map` every cycle.
- Reset values: FSM IDLE, `busy`=0, `done`=0, `verdict`=00, `status_map`=0, `best_slot`=4'hF, `pass_slots`=0, watchdog 0.

## Timing
- `start` at cycle t: ARM at t+1, SNAP at t+2 (if `tester_rst`=0), RUN at t+3.
- A condition first true in RUN at cycle n gives `done` at n+1, `status_map` updated at n+2, `best_slot`/`pass_slots` updated at n+3.
- Minimum `start`-to-`done` time: PASS_TARGET is counted only after SNAP, so it is at least 4 cycles plus the tester's pass period.
- `done` is never asserted in two consecutive cycles.
- Inputs are used as registered in the `clk` domain. The tester counts must already be synchronous to `clk`.

## Configuration
- `MEMTEST_LOG_STICKY_FAIL_EN` defined: a slot holding 10 or 11 is never overwritten by a later 01. A later 10/11 still overwrites a 01.
- Not defined: every RECORD overwrites the slot with the latest verdict.
- `done`/`verdict` behaviour is identical in both builds.

## Test plan
- Pass: after reset, `start` with slot 3. `passcount` steps by 1 every 10 cycles with `failcount` fixed. Required: `done` with `verdict`=01, `status_map[7:6]`=01, `best_slot`=3, `pass_slots`=1.
- Fail priority: in RUN, `failcount` and `passcount` change in the same cycle. Required: `verdict`=10 and slot marked 10.
- Timeout and wrap: TIMEOUT_CYC=50 with counts frozen gives `done` at t+3+50 and `verdict`=11. Separately, `pass_base`=32'hFFFFFFFE with `passcount` advancing to 2 gives `verdict`=01.
- Mid-test reconfig: pulse `tester_rst` high for 20 cycles during RUN. Required: FSM returns through ARM and SNAP, the baseline is re-captured, and no `done` occurs during the reset window.
- Sticky option: record slot 0 as 10, then re-run slot 0 to a pass. With the macro, the slot stays 10 and `best_slot`=4'hF. Without it, the slot becomes 01 and `best_slot`=0.
- Clear/boundaries: `clear` together with `start` gives IDLE and an all-zero map. `start` with slot 11 leaves `busy` at 0.
